usb_wr_sched: RTL and testbench

Scheduler for the USB write FIFO, shared between three word sources: CPU/register writes, the INA stream and the INB stream. It grants the FIFO write port to one source at a time in bounded round-robin bursts and honours the FIFO's full flag. It also generates the FIFO push (commit) pulse, either on CPU request or after an idle timeout. It sits between the register block / input datapaths and the USB FIFO interface.

---
 rtl/usb_wr_sched_if.sv | 23 ++
 rtl/usb_wr_sched.sv | 166 ++++++++++++++++
 tb/tb_usb_wr_sched.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_wr_sched_if.sv
// Source-word handshake and USB FIFO write-port bundle for usb_wr_sched.
// master: the scheduler; slave: the sources and FIFO around it.
interface usb_wr_sched_if;
    logic [2:0]  src_en;
    logic [95:0] src_data;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [31:0] usb_wr_data;
    logic [3:0]  usb_wr_be;
    logic        usb_wr_en;
    logic        usb_wr_fifo_full;
    logic        usb_wr_push;

    modport master (
        input  src_en, src_data, src_valid, usb_wr_fifo_full,
        output src_ready, usb_wr_data, usb_wr_be, usb_wr_en, usb_wr_push
    );

    modport slave (
        output src_en, src_data, src_valid, usb_wr_fifo_full,
        input  src_ready, usb_wr_data, usb_wr_be, usb_wr_en, usb_wr_push
    );
endinterface

// File: rtl/usb_wr_sched.sv
// Round-robin burst scheduler for the shared USB write FIFO, with push-pulse
// generation on CPU request or idle timeout.
module usb_wr_sched #(
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned PUSH_TIMEOUT = 1024,
    parameter int unsigned TW           = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    usb_wr_sched_if.master        bus,
    input  logic                  push_req,
    output logic [1:0]            grant,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {StIdle, StBurst, StPush} state_e;

    state_e         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     last_q, last_d;
    logic [CW-1:0]  burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]  pending_q, pending_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           latch_q, latch_d;
    logic [31:0]    wr_data_q, wr_data_d;
    logic           wr_en_q, wr_en_d;
    logic           push_q, push_d;

    logic [2:0]     req;
    logic [31:0]    sel_data;
    logic           ready_bit;
    logic           accept;
    logic           tmo_hit;
    logic           push_due;
    logic           found;
    logic [1:0]     pick;
    logic [1:0]     cand;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign req       = bus.src_en & bus.src_valid;
    assign ready_bit = !bus.usb_wr_fifo_full && bus.src_en[grant_q];
    assign accept    = (state_q == StBurst) && ready_bit && bus.src_valid[grant_q];
    assign tmo_hit   = (tmo_q == TW'(PUSH_TIMEOUT));
    assign push_due  = (latch_q || tmo_hit) && (pending_q != '0);

    always_comb begin
        unique case (grant_q)
            2'd1:    sel_data = bus.src_data[63:32];
            2'd2:    sel_data = bus.src_data[95:64];
            default: sel_data = bus.src_data[31:0];
        endcase
    end

    always_comb begin
        bus.src_ready = '0;
        if (state_q == StBurst) begin
            bus.src_ready[grant_q] = ready_bit;
        end
    end

    // First requester after the last owner, wrapping modulo 3.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        cand  = last_q;
        for (int k = 0; k < 3; k++) begin
            cand = inc3(cand);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        pending_d   = pending_q;
        tmo_d       = tmo_q;
        latch_d     = latch_q | (push_req && ((pending_q != '0) || accept));
        wr_en_d     = accept;
        wr_data_d   = accept ? sel_data : wr_data_q;
        push_d      = 1'b0;

        if (accept && (pending_q != '1)) begin
            pending_d = pending_q + 1'b1;
        end
        if (accept) begin
            tmo_d = '0;
        end else if ((pending_q != '0) && !tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (push_due) begin
                    state_d = StPush;
                end else if (found) begin
                    grant_d     = pick;
                    last_d      = pick;
                    burst_cnt_d = '0;
                    state_d     = StBurst;
                end
            end
            StBurst: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // Full only stalls; the burst ends on length, loss of valid or enable.
                if ((burst_cnt_d == CW'(BURST_LEN)) || !bus.src_valid[grant_q] ||
                    !bus.src_en[grant_q]) begin
                    state_d = StIdle;
                end
            end
            StPush: begin
                push_d    = 1'b1;
                pending_d = '0;
                latch_d   = 1'b0;
                tmo_d     = '0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grant_q     <= 2'd0;
            last_q      <= 2'd2;
            burst_cnt_q <= '0;
            pending_q   <= '0;
            tmo_q       <= '0;
            latch_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            push_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            pending_q   <= pending_d;
            tmo_q       <= tmo_d;
            latch_q     <= latch_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            push_q      <= push_d;
        end
    end

    assign bus.usb_wr_data = wr_data_q;
    assign bus.usb_wr_be   = {4{wr_en_q}};
    assign bus.usb_wr_en   = wr_en_q;
    assign bus.usb_wr_push = push_q;
    assign grant           = grant_q;
    assign busy            = (state_q == StBurst);

endmodule

// File: tb/tb_usb_wr_sched.sv
// Scoreboard bench for usb_wr_sched: directed source loads, expected write
// order queued up front, monitor compares every FIFO write and push.
module tb_usb_wr_sched;

    localparam int unsigned BL = 4;
    localparam int unsigned PT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push_req = 1'b0;
    logic [1:0] grant;
    logic       busy;

    usb_wr_sched_if bus ();

    usb_wr_sched #(
        .BURST_LEN    (BL),
        .PUSH_TIMEOUT (PT),
        .TW           (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .push_req (push_req),
        .grant    (grant),
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] srcq [3][$];
    logic [31:0] exp_q [$];
    int          runs [$];
    int          cur_run = 0;
    int          wr_cnt = 0;
    int          push_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          last_push_cyc = 0;
    logic [2:0]  acc = 3'b000;
    bit          seen_g1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] mk(input int s, input int n);
        return {4'(s + 1), 12'h000, 16'(n)};
    endfunction

    task automatic load(input int s, input int cnt);
        for (int k = 0; k < cnt; k++) srcq[s].push_back(mk(s, k));
    endtask

    task automatic expect_words(input int s, input int from, input int cnt);
        for (int k = 0; k < cnt; k++) exp_q.push_back(mk(s, from + k));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_wr(input int n);
        int t = 0;
        while (wr_cnt < n && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("write progress", 32'(wr_cnt >= n), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) srcq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        runs.delete();
        cur_run = 0;
    endtask

    // Source driver: pops words accepted at the previous edge, presents the next.
    initial begin
        bus.src_valid = 3'b000;
        bus.src_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
            for (int i = 0; i < 3; i++) begin
                bus.src_valid[i] = (srcq[i].size() > 0);
                bus.src_data[32*i +: 32] = (srcq[i].size() > 0) ? srcq[i][0] : 32'h0;
            end
            #1;
            acc = bus.src_valid & bus.src_ready;
        end
    end

    // Monitor: compares writes against the scoreboard and polices push placement.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && grant == 2'd1) seen_g1 = 1'b1;
            if (bus.src_ready[1]) seen_g1 = 1'b1;
            if (bus.usb_wr_en) begin
                wr_cnt++;
                cur_run++;
                last_wr_cyc = cyc;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("wr_data", bus.usb_wr_data, e);
                check("wr_be", 32'(bus.usb_wr_be), 32'hF);
            end else if (cur_run > 0) begin
                runs.push_back(cur_run);
                cur_run = 0;
            end
            if (bus.usb_wr_push) begin
                push_cnt++;
                last_push_cyc = cyc;
                check("push_with_wr_en", 32'(bus.usb_wr_en), 32'd0);
                check("push_after_write", 32'(cyc > last_wr_cyc), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e1 [3];
        int e2 [6];
        int p0;
        int w;
        int t;
        int d;
        e1 = '{4, 4, 2};
        e2 = '{4, 4, 4, 2, 2, 2};
        bus.src_en = 3'b111;
        bus.usb_wr_fifo_full = 1'b0;

        // Reset state
        #2;
        check("rst wr_en", 32'(bus.usb_wr_en), 32'd0);
        check("rst push", 32'(bus.usb_wr_push), 32'd0);
        check("rst be", 32'(bus.usb_wr_be), 32'd0);
        check("rst data", bus.usb_wr_data, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst grant", 32'(grant), 32'd0);
        check("rst ready", 32'(bus.src_ready), 32'd0);

        // Single-source bursts of BL with one-cycle gaps, then one timeout push
        do_reset();
        p0 = push_cnt;
        load(0, 10);
        expect_words(0, 0, 10);
        wait_drain("single drain", 100);
        repeat (20) @(negedge clk);
        check("single run count", 32'(runs.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("single run len", 32'(runs[i]), 32'(e1[i]));
        check("single timeout push", 32'(push_cnt - p0), 32'd1);

        // Round-robin across three sources
        do_reset();
        for (int s = 0; s < 3; s++) load(s, 6);
        for (int s = 0; s < 3; s++) expect_words(s, 0, 4);
        for (int s = 0; s < 3; s++) expect_words(s, 4, 2);
        wait_drain("rr drain", 200);
        repeat (3) @(negedge clk);
        check("rr run count", 32'(runs.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("rr run len", 32'(runs[i]), 32'(e2[i]));

        // Backpressure mid-burst
        do_reset();
        load(0, 8);
        expect_words(0, 0, 8);
        w = wr_cnt;
        wait_wr(w + 2);
        bus.usb_wr_fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("stall ready", 32'(bus.src_ready), 32'd0);
            check("stall busy", 32'(busy), 32'd1);
            check("stall grant", 32'(grant), 32'd0);
            if (k > 0) check("stall wr_en", 32'(bus.usb_wr_en), 32'd0);
            @(negedge clk);
        end
        bus.usb_wr_fifo_full = 1'b0;
        wait_drain("stall drain", 100);

        // CPU push after three words, then a request with nothing pending
        do_reset();
        load(0, 3);
        expect_words(0, 0, 3);
        wait_drain("push drain", 50);
        p0 = push_cnt;
        push_req = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
        t = 0;
        while (push_cnt == p0 && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("cpu push seen", 32'(push_cnt - p0), 32'd1);
        repeat (12) @(negedge clk);
        check("cpu push single", 32'(push_cnt - p0), 32'd1);
        push_req = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
        repeat (12) @(negedge clk);
        check("empty push dropped", 32'(push_cnt - p0), 32'd1);

        // Idle timeout push
        do_reset();
        p0 = push_cnt;
        load(0, 1);
        expect_words(0, 0, 1);
        wait_drain("tmo drain", 50);
        w = last_wr_cyc;
        t = 0;
        while (push_cnt == p0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        d = last_push_cyc - w;
        check("tmo push seen", 32'(push_cnt - p0), 32'd1);
        check("tmo delay 8..10", 32'(d >= 8 && d <= 10), 32'd1);
        repeat (25) @(negedge clk);
        check("tmo no repeat", 32'(push_cnt - p0), 32'd1);

        // Asynchronous reset mid-burst, then source 0 first after release
        do_reset();
        load(0, 8);
        expect_words(0, 0, 8);
        w = wr_cnt;
        wait_wr(w + 2);
        #2;
        reset = 1'b0;
        #1;
        check("async rst wr_en", 32'(bus.usb_wr_en), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst ready", 32'(bus.src_ready), 32'd0);
        check("async rst data", bus.usb_wr_data, 32'd0);
        check("async rst be", 32'(bus.usb_wr_be), 32'd0);
        for (int i = 0; i < 3; i++) srcq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        load(1, 2);
        load(0, 2);
        expect_words(0, 0, 2);
        expect_words(1, 0, 2);
        wait_drain("post-rst drain", 50);

        // Source 1 masked off
        do_reset();
        bus.src_en = 3'b101;
        seen_g1 = 1'b0;
        for (int s = 0; s < 3; s++) load(s, 5);
        expect_words(0, 0, 4);
        expect_words(2, 0, 4);
        expect_words(0, 4, 1);
        expect_words(2, 4, 1);
        wait_drain("mask drain", 100);
        repeat (5) @(negedge clk);
        check("src1 never granted", 32'(seen_g1), 32'd0);
        check("src1 words untouched", 32'(srcq[1].size()), 32'd5);
        srcq[1].delete();
        bus.src_en = 3'b111;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
